// File: rtl/adc_conv_sequencer_if.sv
// adc_conv_sequencer_if: host request/result, SAR and oversampler signals of the conversion sequencer.
interface adc_conv_sequencer_if #(
  parameter int INTERVAL_W = 16
);
  logic                  start_in;
  logic                  continuous_in;
  logic [2:0]            osr_mode_in;
  logic [INTERVAL_W-1:0] interval_in;
  logic                  sar_start_out;
  logic                  sar_done_in;
  logic [11:0]           sar_data_in;
  logic                  osr_ena_out;
  logic [11:0]           osr_data_out;
  logic [2:0]            osr_mode_out;
  logic                  osr_finished_in;
  logic [15:0]           osr_result_in;
  logic [15:0]           result_out;
  logic                  result_valid_out;
  logic                  result_ack_in;
  logic                  overrun_out;
  logic                  timeout_out;
  logic                  busy_out;
  modport slave (
    input  start_in, continuous_in, osr_mode_in, interval_in, sar_done_in, sar_data_in,
           osr_finished_in, osr_result_in, result_ack_in,
    output sar_start_out, osr_ena_out, osr_data_out, osr_mode_out, result_out,
           result_valid_out, overrun_out, timeout_out, busy_out
  );
  modport master (
    output start_in, continuous_in, osr_mode_in, interval_in, sar_done_in, sar_data_in,
           osr_finished_in, osr_result_in, result_ack_in,
    input  sar_start_out, osr_ena_out, osr_data_out, osr_mode_out, result_out,
           result_valid_out, overrun_out, timeout_out, busy_out
  );
endinterface

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: turns host requests into SAR conversions fed one by one into adc_osr, with result handshake.
// Optional SAR watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_conv_sequencer #(
  parameter int INTERVAL_W = 16
`ifdef ADC_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  adc_conv_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, WAIT_SAR, FEED, CHECK, GAP} state_t;
  state_t                r_state, w_next;
  logic [INTERVAL_W-1:0] r_gap;
  logic [11:0]           r_data;
  logic [2:0]            r_mode;
  logic [15:0]           r_result;
  logic                  r_sar_start, r_ena, r_valid, r_overrun, r_timeout;
  logic                  w_capture, w_ack, w_sar_to;
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait;
  assign w_sar_to = r_state == WAIT_SAR && !bus.sar_done_in && r_wait == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wait <= '0;
    else        r_wait <= r_state == WAIT_SAR ? r_wait + TW'(1) : '0;
`else
  assign w_sar_to = 1'b0;
`endif
  assign w_capture = r_state == CHECK && bus.osr_finished_in;
  assign w_ack     = bus.result_ack_in && r_valid;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (bus.start_in || bus.continuous_in) ? START : IDLE;
      START:    w_next = WAIT_SAR;
      WAIT_SAR: w_next = (bus.sar_done_in || w_sar_to) ? FEED : WAIT_SAR;
      FEED:     w_next = CHECK;
      CHECK:    w_next = (bus.osr_finished_in && !bus.continuous_in) ? IDLE :
                         (bus.interval_in != '0) ? GAP : START;
      GAP:      w_next = r_gap == INTERVAL_W'(1) ? START : GAP;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gap       <= '0;
      r_data      <= '0;
      r_mode      <= '0;
      r_result    <= '0;
      r_sar_start <= 1'b0;
      r_ena       <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_sar_start <= w_next == START;
      r_ena       <= w_next == FEED;
      if (r_state == IDLE && w_next == START) r_mode <= bus.osr_mode_in;
      if (r_state == WAIT_SAR && bus.sar_done_in) r_data <= bus.sar_data_in;
      else if (w_sar_to) r_data <= 12'h800;
      // gap length is frozen at entry so host changes only hit the next gap
      if (r_state == CHECK) r_gap <= bus.interval_in;
      else if (r_state == GAP) r_gap <= r_gap - INTERVAL_W'(1);
      if (w_capture) r_result <= bus.osr_result_in;
      r_valid   <= w_capture || (r_valid && !w_ack);
      r_overrun <= (w_capture && r_valid && !w_ack) || (r_overrun && !w_ack);
      r_timeout <= w_sar_to || (r_timeout && !w_ack);
    end
  assign bus.sar_start_out    = r_sar_start;
  assign bus.osr_ena_out      = r_ena;
  assign bus.osr_data_out     = r_data;
  assign bus.osr_mode_out     = r_mode;
  assign bus.result_out       = r_result;
  assign bus.result_valid_out = r_valid;
  assign bus.overrun_out      = r_overrun;
  assign bus.timeout_out      = r_timeout;
  assign bus.busy_out         = r_state != IDLE;
endmodule
